seg_display_arbiter: RTL and testbench
======================================

// Module: seg_display_arbiter
// PURPOSE
//   Shares the single 8-digit seven-segment display between NUM_SRC requesters
//   (e.g. packet counters, CRC error counts, decoder status words).
//   Uses round-robin arbitration. Each winner's 32-bit value is snapshotted and held
//   for DWELL cycles before the display is re-arbitrated.
//   val_out feeds the seven_segment_controller val_in.
//   src_out/grant_out drive debug LEDs showing which source is on screen.
// PARAMETERS
//   NUM_SRC  4            number of requesters; legal range 2..16
//   DWELL    100_000_000  display hold time in clk_in cycles (1 s @ 100 MHz); >= 1
// PORTS
//   clk_in     input   1                system clock; all logic on posedge
//   rst_in     input   1                synchronous, active-high reset
//   req_in     input   NUM_SRC          level request, one bit per source
//   val_in     input   32*NUM_SRC       source i value at val_in[32*i +: 32]
//   ack_out    output  NUM_SRC          1-cycle pulse: source's value was captured
//   grant_out  output  NUM_SRC          one-hot, source currently displayed; 0 when idle
//   src_out    output  $clog2(NUM_SRC)  index of last granted source
//   val_out    output  32               value to display (snapshot)
//   busy_out   output  1                1 while in SHOW
// BEHAVIOUR
// - All outputs are registered.
// - Reset values:
//   - ack_out=0, grant_out=0, src_out=0, val_out=0, busy_out=0
//   - state=IDLE, dwell counter=0, rr pointer=NUM_SRC-1, so source 0 wins first.
// - FSM IDLE:
//   - If |req_in: pick winner, capture val_in slice, pulse ack_out[winner].
//   - Set grant_out one-hot and src_out=winner; go SHOW with counter=0.
//   - Latency: req at edge t -> grant/ack/val_out visible after edge t+1.
//   - If no request: stay IDLE. val_out and src_out keep their last values
//     (display never blanks).
// - FSM SHOW:
//   - Counter increments each cycle.
//   - At counter==DWELL-1 (the terminal cycle):
//     - if |req_in: re-arbitrate in that same cycle.
//       Back-to-back, no bubble: the new grant, ack and val_out appear on the next edge.
//       The counter restarts at 0.
//     - else: go IDLE, grant_out=0, busy_out=0.
//   - Dwell length per grant is exactly DWELL cycles.
// - Round-robin: search starts at index (ptr+1) mod NUM_SRC, ascending with wrap.
//   - The first requesting source wins; ptr <= winner on every grant.
//   - A sole requester is regranted each dwell.
// - Snapshot semantics:
//   - val_out changes only on a grant edge.
//   - val_in changes during SHOW are ignored.
//   - Deasserting req_in mid-dwell does not shorten the dwell.
// - ack_out is high for exactly 1 cycle per grant, with at most one bit set.
//   Requesters may use it to clear a sticky req.
// - req_in bits that are X or beyond NUM_SRC are not legal; no checking is done.
// - Reset mid-SHOW:
//   - Aborts immediately; all outputs return to reset values on the next edge.
//   - ptr returns to NUM_SRC-1.
// - Counter width is $clog2(DWELL+1); there is no wrap beyond DWELL-1.
// TESTING (NUM_SRC=4, DWELL=4 unless noted)
// 1. Reset, req_in=4'b0001, val0=32'hDEAD_BEEF
//    -> 1 cycle later: grant=0001, ack=0001 for 1 cycle, val_out=DEADBEEF, busy=1.
// 2. req_in=1111 held
//    -> grants cycle 0,1,2,3,0; each grant held exactly 4 cycles, no idle gap.
//    -> exactly one ack pulse per grant.
// 3. Grant src2, then change val2 and drop req2 mid-dwell
//    -> val_out unchanged and grant held 4 cycles, then IDLE.
//    -> val_out keeps the old value, grant_out=0.
// 4. Last grant src3, then req_in=1001
//    -> next winner is src0 (wrap); next after that is src3.
// 5. Assert rst_in during SHOW counter=2
//    -> next edge: all outputs 0, IDLE.
//    -> with req=1111, src0 wins first.
// 6. DWELL=1, req_in=0100 held
//    -> src2 regranted every cycle; ack_out[2] high every cycle; busy stays 1.

Source files
------------

// File: rtl/seg_display_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg_display_arbiter_if
//  Purpose  : Request/value bus between display requesters and the
//             seven-segment display arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface seg_display_arbiter_if #(
  parameter int NUM_SRC = 4
);
  localparam int c_SW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]    req_in;
  logic [32*NUM_SRC-1:0] val_in;
  logic [NUM_SRC-1:0]    ack_out;
  logic [NUM_SRC-1:0]    grant_out;
  logic [c_SW-1:0]       src_out;
  logic [31:0]           val_out;
  logic                  busy_out;

  // Requester side drives requests and values, observes the display state.
  modport master (
    output req_in, val_in,
    input  ack_out, grant_out, src_out, val_out, busy_out
  );

  modport slave (
    input  req_in, val_in,
    output ack_out, grant_out, src_out, val_out, busy_out
  );
endinterface
`default_nettype wire

// File: rtl/seg_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : seg_display_arbiter
//  Purpose  : Round-robin sharing of one 8-digit display; each winner's value
//             is snapshotted and held for DWELL cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module seg_display_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DWELL   = 100_000_000
) (
  input  wire                    clk_in,
  input  wire                    rst_in,
  seg_display_arbiter_if.slave   bus
);
  localparam int c_SW = $clog2(NUM_SRC);
  localparam int c_CW = $clog2(DWELL + 1);

  localparam logic [c_CW-1:0] c_TERM    = c_CW'(DWELL - 1);
  localparam logic [c_SW-1:0] c_PTR_RST = c_SW'(NUM_SRC - 1);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_SHOW = 1'b1;

  logic [0:0]         r_state;
  logic [c_CW-1:0]    r_cnt;
  logic [c_SW-1:0]    r_ptr;
  logic [NUM_SRC-1:0] r_ack;
  logic [NUM_SRC-1:0] r_grant;
  logic [c_SW-1:0]    r_src;
  logic [31:0]        r_val;
  logic               r_busy;

  logic               w_found;
  logic [c_SW-1:0]    w_win;
  logic [NUM_SRC-1:0] w_onehot;
  logic [31:0]        w_val;
  int                 w_idx;

  // Scan starts just after the last winner and wraps, so every source is
  // reached within NUM_SRC grants.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NUM_SRC) begin
        w_idx = w_idx - NUM_SRC;
      end
      if (!w_found && bus.req_in[c_SW'(w_idx)]) begin
        w_found = 1'b1;
        w_win   = c_SW'(w_idx);
      end
    end
  end

  always_comb begin
    w_onehot = '0;
    w_val    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_win == c_SW'(i)) begin
        w_onehot[i] = 1'b1;
        w_val       = bus.val_in[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_ptr   <= c_PTR_RST;
      r_ack   <= '0;
      r_grant <= '0;
      r_src   <= '0;
      r_val   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_ack <= '0;
      case (r_state)
        c_IDLE: begin
          if (w_found) begin
            r_state <= c_SHOW;
            r_cnt   <= '0;
            r_ptr   <= w_win;
            r_ack   <= w_onehot;
            r_grant <= w_onehot;
            r_src   <= w_win;
            r_val   <= w_val;
            r_busy  <= 1'b1;
          end
        end
        c_SHOW: begin
          if (r_cnt == c_TERM) begin
            // Terminal cycle: hand straight over to the next winner if any.
            if (w_found) begin
              r_cnt   <= '0;
              r_ptr   <= w_win;
              r_ack   <= w_onehot;
              r_grant <= w_onehot;
              r_src   <= w_win;
              r_val   <= w_val;
            end else begin
              r_state <= c_IDLE;
              r_cnt   <= '0;
              r_grant <= '0;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_cnt   <= '0;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack_out   = r_ack;
  assign bus.grant_out = r_grant;
  assign bus.src_out   = r_src;
  assign bus.val_out   = r_val;
  assign bus.busy_out  = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_display_arbiter
//  Purpose  : Directed and random checks of two arbiters (DWELL=4, DWELL=1)
//             against a dwell-countdown reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_arbiter;
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_v [2];
  logic [3:0]  req_v [2];
  logic [31:0] vals  [2][4];

  seg_display_arbiter_if #(.NUM_SRC(4)) bus_a ();
  seg_display_arbiter_if #(.NUM_SRC(4)) bus_b ();

  assign bus_a.req_in = req_v[0];
  assign bus_a.val_in = {vals[0][3], vals[0][2], vals[0][1], vals[0][0]};
  assign bus_b.req_in = req_v[1];
  assign bus_b.val_in = {vals[1][3], vals[1][2], vals[1][1], vals[1][0]};

  seg_display_arbiter #(.NUM_SRC(4), .DWELL(4)) u_dut_a (
    .clk_in (clk_in),
    .rst_in (rst_v[0]),
    .bus    (bus_a)
  );

  seg_display_arbiter #(.NUM_SRC(4), .DWELL(1)) u_dut_b (
    .clk_in (clk_in),
    .rst_in (rst_v[1]),
    .bus    (bus_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a showing flag plus remaining dwell cycles per DUT.
  int          c_dwell [2] = '{4, 1};
  bit          m_show  [2];
  int          m_left  [2];
  int          m_ptr   [2];
  int          m_src   [2];
  logic [31:0] m_val   [2];
  logic [3:0]  m_ack   [2];
  logic [3:0]  m_grant [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_step(input int d);
    int win;
    bit found;
    if (rst_v[d]) begin
      m_show[d] = 1'b0; m_left[d] = 0; m_ptr[d] = 3; m_src[d] = 0;
      m_val[d] = '0; m_ack[d] = '0; m_grant[d] = '0;
    end else begin
      m_ack[d] = '0;
      if (m_show[d] && m_left[d] > 1) begin
        m_left[d]--;
      end else if (req_v[d] != 4'b0) begin
        found = 1'b0;
        win   = 0;
        for (int k = 1; k <= 4; k++) begin
          if (!found && req_v[d][(m_ptr[d] + k) % 4]) begin
            found = 1'b1;
            win   = (m_ptr[d] + k) % 4;
          end
        end
        m_show[d]  = 1'b1;
        m_left[d]  = c_dwell[d];
        m_ptr[d]   = win;
        m_src[d]   = win;
        m_val[d]   = vals[d][win];
        m_ack[d]   = 4'(1 << win);
        m_grant[d] = 4'(1 << win);
      end else begin
        m_show[d]  = 1'b0;
        m_grant[d] = '0;
      end
    end
  endfunction

  task automatic check_model(input int d, input logic [3:0] ack, input logic [3:0] grant,
                             input logic [1:0] src, input logic [31:0] val, input logic busy);
    string n;
    n = (d == 0) ? "a" : "b";
    check({n, ".ack"},   {28'b0, ack},   {28'b0, m_ack[d]});
    check({n, ".grant"}, {28'b0, grant}, {28'b0, m_grant[d]});
    check({n, ".src"},   {30'b0, src},   32'(m_src[d]));
    check({n, ".val"},   val,            m_val[d]);
    check({n, ".busy"},  {31'b0, busy},  {31'b0, m_show[d]});
  endtask

  task automatic cycle();
    @(posedge clk_in);
    #1;
    for (int d = 0; d < 2; d++) model_step(d);
    check_model(0, bus_a.ack_out, bus_a.grant_out, bus_a.src_out, bus_a.val_out, bus_a.busy_out);
    check_model(1, bus_b.ack_out, bus_b.grant_out, bus_b.src_out, bus_b.val_out, bus_b.busy_out);
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    int got[$];
    int busy_n;
    int exp2[5] = '{0, 1, 2, 3, 0};

    for (int d = 0; d < 2; d++) begin
      rst_v[d] = 1'b1; req_v[d] = '0;
      for (int s = 0; s < 4; s++) vals[d][s] = '0;
    end
    cycle(); cycle();
    check("rst.grant", {28'b0, bus_a.grant_out}, 32'h0);
    check("rst.busy",  {31'b0, bus_a.busy_out},  32'h0);
    check("rst.val",   bus_a.val_out,            32'h0);

    // Sole requester from reset
    rst_v[0] = 1'b0; req_v[0] = 4'b0001; vals[0][0] = 32'hDEAD_BEEF;
    cycle();
    check("t1.grant", {28'b0, bus_a.grant_out}, 32'h1);
    check("t1.ack",   {28'b0, bus_a.ack_out},   32'h1);
    check("t1.val",   bus_a.val_out,            32'hDEAD_BEEF);
    check("t1.busy",  {31'b0, bus_a.busy_out},  32'h1);
    req_v[0] = 4'b0;
    cycle();
    check("t1.ack_pulse", {28'b0, bus_a.ack_out}, 32'h0);
    repeat (4) cycle();

    // All sources requesting: strict rotation without idle gaps
    rst_v[0] = 1'b1; cycle();
    rst_v[0] = 1'b0; req_v[0] = 4'hF;
    for (int s = 0; s < 4; s++) vals[0][s] = 32'h1000_0000 + 32'(s);
    busy_n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bus_a.ack_out != 4'b0) got.push_back(oh_idx(bus_a.ack_out));
      if (bus_a.busy_out) busy_n++;
    end
    check("t2.ack_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) check("t2.order", 32'(got[i]), 32'(exp2[i]));
    end
    check("t2.busy_cycles", 32'(busy_n), 32'd20);

    // Snapshot holds through value change and request drop
    rst_v[0] = 1'b1; cycle();
    rst_v[0] = 1'b0; req_v[0] = 4'b0100; vals[0][2] = 32'h1111_2222;
    cycle();
    check("t3.src", {30'b0, bus_a.src_out}, 32'd2);
    vals[0][2] = 32'h5555_6666; req_v[0] = 4'b0;
    repeat (3) begin
      cycle();
      check("t3.hold_val",   bus_a.val_out,            32'h1111_2222);
      check("t3.hold_grant", {28'b0, bus_a.grant_out}, 32'h4);
    end
    cycle();
    check("t3.idle_grant", {28'b0, bus_a.grant_out}, 32'h0);
    check("t3.idle_busy",  {31'b0, bus_a.busy_out},  32'h0);
    check("t3.idle_val",   bus_a.val_out,            32'h1111_2222);

    // Round-robin wrap from source 3
    req_v[0] = 4'b1000;
    cycle();
    check("t4.src3", {30'b0, bus_a.src_out}, 32'd3);
    req_v[0] = 4'b1001;
    repeat (3) cycle();
    cycle();
    check("t4.wrap_src0", {30'b0, bus_a.src_out}, 32'd0);
    repeat (3) cycle();
    cycle();
    check("t4.next_src3", {30'b0, bus_a.src_out}, 32'd3);

    // Reset in the middle of a dwell
    cycle(); cycle();
    rst_v[0] = 1'b1;
    cycle();
    check("t5.grant", {28'b0, bus_a.grant_out}, 32'h0);
    check("t5.ack",   {28'b0, bus_a.ack_out},   32'h0);
    check("t5.src",   {30'b0, bus_a.src_out},   32'h0);
    check("t5.val",   bus_a.val_out,            32'h0);
    check("t5.busy",  {31'b0, bus_a.busy_out},  32'h0);
    rst_v[0] = 1'b0; req_v[0] = 4'hF;
    cycle();
    check("t5.first", {28'b0, bus_a.grant_out}, 32'h1);

    // Single-cycle dwell with a sole requester
    rst_v[1] = 1'b0; req_v[1] = 4'b0100; vals[1][2] = 32'hCAFE_0002;
    repeat (6) begin
      cycle();
      check("t6.ack",   {28'b0, bus_b.ack_out},   32'h4);
      check("t6.grant", {28'b0, bus_b.grant_out}, 32'h4);
      check("t6.busy",  {31'b0, bus_b.busy_out},  32'h1);
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        rst_v[d] = ($urandom_range(0, 49) == 0);
        req_v[d] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) begin
          for (int s = 0; s < 4; s++) vals[d][s] = $urandom;
        end
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
